// File: rtl/red_neuronal_pkg.sv
// ---------------------------------------------------------------------------
// red_neuronal_pkg
// Shared definitions for the neural network layer blocks.
//   Width / Magnitud / Precision : Q7.24 signed fixed-point format constants
//   estado_t                     : state encoding of the activation scheduler
// ---------------------------------------------------------------------------
package red_neuronal_pkg;

    localparam int Width     = 32;
    localparam int Magnitud  = 7;
    localparam int Precision = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } estado_t;

endpackage

// File: rtl/activacion_scheduler_arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Combinational round-robin priority encoder.
// The search begins one position past the last accepted requester and wraps
// around, so every requester is eventually reached.
//
// Ports:
//   Req_Valid [NNeuronas]  in  : request vector, bit i = neuron i has a value
//   Ultimo    [IdWidth]    in  : index of the last accepted requester
//   Cand      [IdWidth]    out : first valid requester in round-robin order
//   Hay                    out : at least one request is valid
// ---------------------------------------------------------------------------
module arbitro_rr #(
    parameter int NNeuronas = 4,
    parameter int IdWidth   = 2
) (
    input  logic [NNeuronas-1:0] Req_Valid,
    input  logic [IdWidth-1:0]   Ultimo,
    output logic [IdWidth-1:0]   Cand,
    output logic                 Hay
);

    int idx;

    // Walk NNeuronas positions starting right after Ultimo; the last step
    // lands on Ultimo itself, so it only wins when nobody else is asking.
    always_comb begin
        Cand = '0;
        Hay  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= NNeuronas; k++) begin
            idx = (int'(Ultimo) + k) % NNeuronas;
            if (!Hay && Req_Valid[idx]) begin
                Hay  = 1'b1;
                Cand = IdWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/activacion_scheduler.sv
// ---------------------------------------------------------------------------
// activacion_scheduler
// Shares one combinational piecewise-linear activation unit among NNeuronas
// neuron accumulators. One pre-activation value is accepted per grant, the
// unit is driven for a single evaluation cycle and its result is registered
// together with the requester ID and the unit's error flag, then held behind
// a valid/ready handshake.
//
// Ports:
//   CLK, RST                 : clock, synchronous active-low reset
//   Req_Valid/Req_Datos      : per-neuron request and value (neuron i at
//                              bits [i*Width +: Width])
//   Req_Ready                : one-hot combinational grant
//   Act_Entrada/Act_Enable   : operand and enable towards the activation unit
//   Act_Salida/Act_Error     : result and error flag from the activation unit
//   Out_Valid/Out_Ready      : result handshake
//   Out_Datos/Out_Id/Out_Error : held result, its neuron index and error flag
//   Ocupado                  : high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module activacion_scheduler #(
    parameter int Width     = red_neuronal_pkg::Width,
    parameter int NNeuronas = 4,
    parameter int IdWidth   = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NNeuronas-1:0]       Req_Valid,
    input  logic [NNeuronas*Width-1:0] Req_Datos,
    output logic [NNeuronas-1:0]       Req_Ready,
    output logic [Width-1:0]           Act_Entrada,
    output logic                       Act_Enable,
    input  logic [Width-1:0]           Act_Salida,
    input  logic                       Act_Error,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [Width-1:0]           Out_Datos,
    output logic [IdWidth-1:0]         Out_Id,
    output logic                       Out_Error,
    output logic                       Ocupado
);

    import red_neuronal_pkg::*;

    estado_t              estado;
    estado_t              estadoSig;
    logic [IdWidth-1:0]   Ultimo;
    logic [IdWidth-1:0]   Id;
    logic [IdWidth-1:0]   cand;
    logic                 hay;
    logic                 puedeConceder;
    logic                 acepta;
    logic [Width-1:0]     datoSel;

    arbitro_rr #(
        .NNeuronas (NNeuronas),
        .IdWidth   (IdWidth)
    ) u_arbitro (
        .Req_Valid (Req_Valid),
        .Ultimo    (Ultimo),
        .Cand      (cand),
        .Hay       (hay)
    );

    // A new value can only be taken when the result slot is free, or is being
    // emptied in this very cycle. Grants are suppressed while reset is held so
    // nothing is handed out during reset.
    always_comb begin
        puedeConceder = (estado == IDLE) || (estado == HOLD && Out_Ready);
        acepta        = hay && puedeConceder && RST;
    end

    // Grant and operand mux for the selected candidate.
    always_comb begin
        Req_Ready = '0;
        datoSel   = '0;
        for (int i = 0; i < NNeuronas; i++) begin
            if (int'(cand) == i) begin
                Req_Ready[i] = acepta;
                datoSel      = Req_Datos[i*Width +: Width];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        estadoSig = estado;
        case (estado)
            IDLE: if (acepta) estadoSig = EVAL;
            EVAL: estadoSig = HOLD;
            HOLD: if (Out_Ready) estadoSig = acepta ? EVAL : IDLE;
            default: estadoSig = IDLE;
        endcase
    end

    always_comb begin
        Act_Enable = (estado == EVAL);
        Ocupado    = (estado != IDLE);
    end

    // State, operand capture and result registers. Ultimo restarts at the
    // highest index so that neuron 0 wins the first arbitration.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            estado      <= IDLE;
            Ultimo      <= IdWidth'(NNeuronas - 1);
            Id          <= '0;
            Act_Entrada <= '0;
            Out_Datos   <= '0;
            Out_Id      <= '0;
            Out_Error   <= 1'b0;
            Out_Valid   <= 1'b0;
        end else begin
            estado <= estadoSig;
            if (acepta) begin
                Act_Entrada <= datoSel;
                Id          <= cand;
                Ultimo      <= cand;
            end
            if (estado == EVAL) begin
                Out_Datos <= Act_Salida;
                Out_Error <= Act_Error;
                Out_Id    <= Id;
                Out_Valid <= 1'b1;
            end else if (estado == HOLD && Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_activacion_scheduler.sv
// ---------------------------------------------------------------------------
// tb_activacion_scheduler
// Self-checking bench for activacion_scheduler with a behavioural model of the
// shared activation unit and a scoreboard of accepted requests.
// ---------------------------------------------------------------------------
module tb_activacion_scheduler;

    logic        CLK;
    logic        RST;
    logic [3:0]  Req_Valid;
    logic [127:0] Req_Datos;
    logic [3:0]  Req_Ready;
    logic [31:0] Act_Entrada;
    logic        Act_Enable;
    logic [31:0] Act_Salida;
    logic        Act_Error;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Datos;
    logic [1:0]  Out_Id;
    logic        Out_Error;
    logic        Ocupado;

    logic [31:0] datos [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] datos;
        logic        err;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        logic [3:0] valid;
        logic       outReady;
        logic [3:0] expReady;
        logic       expEnable;
        logic       expOutValid;
        logic [1:0] expOutId;
        logic       expOcupado;
    } vec_t;

    vec_t tabla [10];

    logic [31:0] capDatos;
    logic [1:0]  capId;
    logic        capError;

    activacion_scheduler #(
        .Width     (32),
        .NNeuronas (4),
        .IdWidth   (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Req_Valid   (Req_Valid),
        .Req_Datos   (Req_Datos),
        .Req_Ready   (Req_Ready),
        .Act_Entrada (Act_Entrada),
        .Act_Enable  (Act_Enable),
        .Act_Salida  (Act_Salida),
        .Act_Error   (Act_Error),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Out_Datos   (Out_Datos),
        .Out_Id      (Out_Id),
        .Out_Error   (Out_Error),
        .Ocupado     (Ocupado)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the activation unit living at layer level.
    function automatic logic [31:0] modeloAct(input logic [31:0] e);
        if (e == 32'h0100_0000) return 32'h00BB_0000;
        return e ^ 32'h5A5A_0000;
    endfunction

    function automatic logic modeloErr(input logic [31:0] e);
        return e == 32'h7F00_0000;
    endfunction

    always_comb begin
        Req_Datos  = {datos[3], datos[2], datos[1], datos[0]};
        Act_Salida = modeloAct(Act_Entrada);
        Act_Error  = modeloErr(Act_Entrada);
    end

    task automatic checkOutput(input string nombre, input logic [31:0] actual,
                               input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nombre, actual, esperado, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return in the
    // middle of that cycle so the caller can sample settled outputs.
    task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                                 input logic outReady);
        @(posedge CLK);
        #1;
        RST       = rst;
        Req_Valid = valid;
        Out_Ready = outReady;
        @(negedge CLK);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rst_req_ready", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("rst_out_datos", Out_Datos, 32'd0);
        checkOutput("rst_out_id", {30'd0, Out_Id}, 32'd0);
        checkOutput("rst_out_error", {31'd0, Out_Error}, 32'd0);
        checkOutput("rst_act_entrada", Act_Entrada, 32'd0);
        checkOutput("rst_act_enable", {31'd0, Act_Enable}, 32'd0);
        checkOutput("rst_ocupado", {31'd0, Ocupado}, 32'd0);
    endtask

    // Scoreboard: accepts push the expected result, handshakes pop and compare.
    always @(negedge CLK) begin
        if (!RST) begin
            sb.delete();
        end else begin
            if (Out_Valid && Out_Ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_result", {30'd0, Out_Id}, 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    checkOutput("sb_out_id", {30'd0, Out_Id}, {30'd0, e.id});
                    checkOutput("sb_out_datos", Out_Datos, e.datos);
                    checkOutput("sb_out_error", {31'd0, Out_Error}, {31'd0, e.err});
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (Req_Valid[i] && Req_Ready[i]) begin
                    sb_t n;
                    n.id    = 2'(i);
                    n.datos = modeloAct(datos[i]);
                    n.err   = modeloErr(datos[i]);
                    sb.push_back(n);
                end
            end
        end
    end

    initial begin
        RST       = 1'b0;
        Req_Valid = 4'b0000;
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) datos[i] = 32'd0;

        //            valid    ordy  expReady en  ov  id    oc
        tabla[0] = '{4'b1111, 1'b1, 4'b0001, 0,  0,  2'd0, 0};
        tabla[1] = '{4'b1111, 1'b1, 4'b0000, 1,  0,  2'd0, 1};
        tabla[2] = '{4'b1111, 1'b1, 4'b0010, 0,  1,  2'd0, 1};
        tabla[3] = '{4'b1111, 1'b1, 4'b0000, 1,  0,  2'd0, 1};
        tabla[4] = '{4'b1111, 1'b1, 4'b0100, 0,  1,  2'd1, 1};
        tabla[5] = '{4'b1111, 1'b1, 4'b0000, 1,  0,  2'd0, 1};
        tabla[6] = '{4'b1111, 1'b1, 4'b1000, 0,  1,  2'd2, 1};
        tabla[7] = '{4'b1111, 1'b1, 4'b0000, 1,  0,  2'd0, 1};
        tabla[8] = '{4'b1111, 1'b1, 4'b0001, 0,  1,  2'd3, 1};
        tabla[9] = '{4'b1111, 1'b1, 4'b0000, 1,  0,  2'd0, 1};

        // All four neurons requesting continuously from reset.
        $display("[TB] round-robin table");
        datos[0] = 32'h0010_0000;
        datos[1] = 32'h0020_0000;
        datos[2] = 32'h0030_0000;
        datos[3] = 32'h0040_0000;
        doReset();
        for (int v = 0; v < 10; v++) begin
            applyStimulus(1'b1, tabla[v].valid, tabla[v].outReady);
            checkOutput($sformatf("rr%0d_req_ready", v), {28'd0, Req_Ready}, {28'd0, tabla[v].expReady});
            checkOutput($sformatf("rr%0d_act_enable", v), {31'd0, Act_Enable}, {31'd0, tabla[v].expEnable});
            checkOutput($sformatf("rr%0d_out_valid", v), {31'd0, Out_Valid}, {31'd0, tabla[v].expOutValid});
            checkOutput($sformatf("rr%0d_ocupado", v), {31'd0, Ocupado}, {31'd0, tabla[v].expOcupado});
            if (tabla[v].expOutValid)
                checkOutput($sformatf("rr%0d_out_id", v), {30'd0, Out_Id}, {30'd0, tabla[v].expOutId});
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("rr_drain_ocupado", {31'd0, Ocupado}, 32'd0);

        // Single request from neuron 2.
        $display("[TB] single request");
        doReset();
        datos[2] = 32'h0100_0000;
        applyStimulus(1'b1, 4'b0100, 1'b1);
        checkOutput("t1_req_ready", {28'd0, Req_Ready}, 32'b0100);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t1_act_enable", {31'd0, Act_Enable}, 32'd1);
        checkOutput("t1_act_entrada", Act_Entrada, 32'h0100_0000);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t1_out_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("t1_out_datos", Out_Datos, 32'h00BB_0000);
        checkOutput("t1_out_id", {30'd0, Out_Id}, 32'd2);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t1_idle_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("t1_idle_ocupado", {31'd0, Ocupado}, 32'd0);

        // Backpressure: neurons 0 and 3 requesting, last winner was 2.
        $display("[TB] backpressure");
        datos[0] = 32'h0020_0000;
        datos[3] = 32'h0030_0000;
        applyStimulus(1'b1, 4'b1001, 1'b0);
        checkOutput("t3_grant3", {28'd0, Req_Ready}, 32'b1000);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t3_eval_no_grant", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t3_out_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("t3_out_id", {30'd0, Out_Id}, 32'd3);
        checkOutput("t3_out_datos", Out_Datos, 32'h0030_0000 ^ 32'h5A5A_0000);
        capDatos = Out_Datos;
        capId    = Out_Id;
        capError = Out_Error;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 4'b0001, 1'b0);
            checkOutput($sformatf("t3_hold%0d_datos", c), Out_Datos, capDatos);
            checkOutput($sformatf("t3_hold%0d_id", c), {30'd0, Out_Id}, {30'd0, capId});
            checkOutput($sformatf("t3_hold%0d_error", c), {31'd0, Out_Error}, {31'd0, capError});
            checkOutput($sformatf("t3_hold%0d_no_grant", c), {28'd0, Req_Ready}, 32'd0);
            checkOutput($sformatf("t3_hold%0d_valid", c), {31'd0, Out_Valid}, 32'd1);
        end
        applyStimulus(1'b1, 4'b0001, 1'b1);
        checkOutput("t3_grant_on_ready", {28'd0, Req_Ready}, 32'b0001);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t3_eval2_enable", {31'd0, Act_Enable}, 32'd1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t3_second_id", {30'd0, Out_Id}, 32'd0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t3_idle", {31'd0, Ocupado}, 32'd0);

        // Error flag travels with its own result only.
        $display("[TB] error propagation");
        datos[1] = 32'h7F00_0000;
        applyStimulus(1'b1, 4'b0010, 1'b1);
        checkOutput("t4_grant1", {28'd0, Req_Ready}, 32'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t4_out_error1", {31'd0, Out_Error}, 32'd1);
        checkOutput("t4_out_datos1", Out_Datos, 32'h255A_0000);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        datos[1] = 32'h0040_0000;
        applyStimulus(1'b1, 4'b0010, 1'b1);
        checkOutput("t4_regrant1", {28'd0, Req_Ready}, 32'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t4_out_error0", {31'd0, Out_Error}, 32'd0);
        checkOutput("t4_out_datos2", Out_Datos, 32'h5A1A_0000);
        applyStimulus(1'b1, 4'b0000, 1'b1);

        // Reset while evaluating drops the pending result.
        $display("[TB] reset in eval");
        datos[2] = 32'h0050_0000;
        datos[3] = 32'h0060_0000;
        applyStimulus(1'b1, 4'b1100, 1'b1);
        checkOutput("t5_grant2", {28'd0, Req_Ready}, 32'b0100);
        datos[1] = 32'h0070_0000;
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("t5_no_grant_in_reset", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b1, 4'b1010, 1'b1);
        checkOutput("t5_out_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("t5_ocupado", {31'd0, Ocupado}, 32'd0);
        checkOutput("t5_act_enable", {31'd0, Act_Enable}, 32'd0);
        checkOutput("t5_lowest_grant", {28'd0, Req_Ready}, 32'b0010);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t5_act_entrada", Act_Entrada, 32'h0070_0000);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t5_out_id", {30'd0, Out_Id}, 32'd1);
        applyStimulus(1'b1, 4'b0000, 1'b1);

        // Withdrawn request from neuron 1 while neuron 0's result is held.
        $display("[TB] withdrawn request");
        datos[0] = 32'h0080_0000;
        datos[1] = 32'h0090_0000;
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t6_grant0", {28'd0, Req_Ready}, 32'b0001);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("t6_held_id", {30'd0, Out_Id}, 32'd0);
        checkOutput("t6_no_grant_a", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("t6_no_grant_b", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t6_no_grant_c", {28'd0, Req_Ready}, 32'd0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkOutput("t6_idle_ocupado", {31'd0, Ocupado}, 32'd0);
        checkOutput("t6_idle_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("t6_idle_no_grant", {28'd0, Req_Ready}, 32'd0);

        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
